// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO stream reader.
// Covers the output buffer depth, default widths, the occupancy type and the occupancy arithmetic.
package fifo_stream_pkg;

    localparam int SKID_DEPTH = 2;
    localparam int DEF_W      = 6;
    localparam int DEF_CNT_W  = 16;

    typedef logic [1:0] occ_t;

    // Occupancy after one clock of optional write and optional pop.
    function automatic occ_t occ_step(input occ_t occ, input logic wr, input logic pop);
        return occ_t'(occ + occ_t'(wr) - occ_t'(pop));
    endfunction

    // True when a new read may be issued.
    // The check counts the held words, plus the word already in flight, minus the word leaving this cycle.
    // A pop only happens with occ >= 1, so the subtraction cannot underflow.
    function automatic logic has_room(input occ_t occ, input logic pend, input logic pop);
        logic [2:0] after;
        after = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
        return after < 3'(SKID_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order register buffer that absorbs the FIFO read latency.
// Entry 0 is the head presented downstream. Entry 1 is the skid slot.
module fifo_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int W = DEF_W
)
(
    input  logic         clk,
    input  logic         arst_n,
    input  logic         wr_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         valid_o,
    output occ_t         occ_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    occ_t         occ_q,  occ_d;
    occ_t         slot;

    // Next-state logic.
    // On a pop from a full buffer the skid entry moves to the head.
    // Any incoming word then lands in the first free slot that remains after the pop.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_step(occ_q, wr_i, pop_i);
        slot   = occ_t'(occ_q - occ_t'(pop_i));
        if (pop_i && occ_q == occ_t'(SKID_DEPTH)) begin
            head_d = tail_q;
        end
        if (wr_i) begin
            if (slot == 2'd0) begin
                head_d = wr_data_i;
            end else begin
                tail_d = wr_data_i;
            end
        end
    end

    // Buffer registers. Everything, including the data entries, clears on reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_o  = head_q;
    assign valid_o = (occ_q != 2'd0);
    assign occ_o   = occ_q;

    // A word landing on a full buffer without a pop would be lost.
    a_no_overflow : assert property (@(posedge clk) disable iff (!arst_n)
        !(wr_i && occ_q == occ_t'(SKID_DEPTH) && !pop_i));

    // Popping an empty buffer would duplicate a stale word.
    a_no_underflow : assert property (@(posedge clk) disable iff (!arst_n)
        !(pop_i && occ_q == 2'd0));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO (one-cycle read latency) into a valid/ready stream.
// Runs at one word per clock and counts the words the sink accepts.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
)
(
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [W-1:0]     fifo_data,
    output logic             fifo_rd_en,
    output logic [W-1:0]     m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             busy
);

    logic             pend_q,  pend_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             pop;
    logic             buf_valid;
    logic [W-1:0]     buf_head;
    occ_t             occ;

    assign pop = buf_valid && m_ready;

    // A read is issued only when the returning word is guaranteed a slot.
    // The read strobe is held low during reset so that the FIFO is never strobed.
    assign fifo_rd_en = arst_n && en && !fifo_empty && has_room(occ, pend_q, pop);

    // Control next-state: the strobe becomes the capture flag, and each pop advances the counter.
    always_comb begin
        pend_d = fifo_rd_en;
        cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, pop};
    end

    // Control registers. A pending read is dropped on reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    fifo_skid_buf #(
        .W (W)
    ) u_skid (
        .clk       (clk),
        .arst_n    (arst_n),
        .wr_i      (pend_q),
        .wr_data_i (fifo_data),
        .pop_i     (pop),
        .head_o    (buf_head),
        .valid_o   (buf_valid),
        .occ_o     (occ)
    );

    assign m_data   = buf_head;
    assign m_valid  = buf_valid;
    assign beat_cnt = cnt_q;
    assign busy     = (occ != 2'd0) || pend_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader.
// A queue-based FIFO feeds the DUT. A queue model of the output buffer predicts every output on every cycle.
module tb_fifo_stream_reader;

    localparam int W     = 6;
    localparam int CNT_W = 4;

    logic             clk;
    logic             arst_n;
    logic             en;
    logic             fifo_empty;
    logic [W-1:0]     fifo_data;
    logic             fifo_rd_en;
    logic [W-1:0]     m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CNT_W-1:0] beat_cnt;
    logic             busy;

    int n_pass;
    int n_total;

    logic [W-1:0]     fq[$];
    logic [W-1:0]     mq[$];
    logic             m_pend;
    logic [W-1:0]     m_word;
    logic [CNT_W-1:0] m_cnt;
    logic             prev_stall;
    logic [W-1:0]     prev_data;
    logic [W-1:0]     delivered[$];
    bit               rd_hist[$];
    logic             rd_s;

    fifo_stream_reader #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .beat_cnt   (beat_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Compare the delivered words against the run start, start+1, ...
    task automatic check_seq(input string name, input int start, input int n);
        check({name, "_count"}, delivered.size(), n);
        for (int i = 0; i < n && i < delivered.size(); i++) begin
            check({name, "_word"}, {26'd0, delivered[i]}, start + i);
        end
    endtask

    function automatic int rd_count();
        int c = 0;
        foreach (rd_hist[i]) if (rd_hist[i]) c++;
        return c;
    endfunction

    function automatic int rd_maxrun();
        int run = 0;
        int best = 0;
        foreach (rd_hist[i]) begin
            run = rd_hist[i] ? run + 1 : 0;
            if (run > best) best = run;
        end
        return best;
    endfunction

    // Model of the stream: mq holds the words that are visible or queued.
    // m_pend/m_word hold the word that returns from the FIFO at the next edge.
    task automatic model_compare();
        logic         exp_valid;
        logic         exp_rd;
        logic         exp_busy;
        logic         pop;
        int           held;
        if (!arst_n) begin
            mq.delete();
            m_pend     = 1'b0;
            m_cnt      = '0;
            prev_stall = 1'b0;
        end
        exp_valid = (mq.size() != 0);
        pop       = exp_valid && m_ready;
        held      = mq.size() + int'(m_pend) - int'(pop);
        exp_rd    = arst_n && en && !fifo_empty && (held < 2);
        exp_busy  = exp_valid || m_pend;

        check("m_valid", {31'd0, m_valid}, {31'd0, exp_valid});
        if (exp_valid) check("m_data", {26'd0, m_data}, {26'd0, mq[0]});
        check("beat_cnt", {28'd0, beat_cnt}, {28'd0, m_cnt});
        check("busy", {31'd0, busy}, {31'd0, exp_busy});
        check("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
        if (prev_stall) begin
            check("stall_valid", {31'd0, m_valid}, 32'd1);
            check("stall_data", {26'd0, m_data}, {26'd0, prev_data});
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (m_valid && m_ready) delivered.push_back(m_data);
        rd_hist.push_back(fifo_rd_en);

        if (pop) begin
            void'(mq.pop_front());
            m_cnt = m_cnt + 1'b1;
        end
        if (m_pend) mq.push_back(m_word);
        m_pend = exp_rd;
        if (exp_rd && fq.size() != 0) m_word = fq[0];
    endtask

    // One clock: compare at the falling edge, then let the FIFO respond just after the rising edge.
    task automatic tick();
        @(negedge clk);
        model_compare();
        rd_s = fifo_rd_en;
        @(posedge clk);
        #1;
        if (!arst_n) begin
            fq.delete();
            fifo_data = '0;
        end else if (rd_s && fq.size() != 0) begin
            fifo_data = fq.pop_front();
        end
        fifo_empty = (fq.size() == 0);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input int start, input int n);
        for (int i = 0; i < n; i++) fq.push_back(W'(start + i));
    endtask

    task automatic clear_logs();
        delivered.delete();
        rd_hist.delete();
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        arst_n     = 1'b1;
        en         = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        m_pend     = 1'b0;
        m_word     = '0;
        m_cnt      = '0;
        prev_stall = 1'b0;
        prev_data  = '0;
        rd_s       = 1'b0;
        #1 arst_n = 1'b0;
        #2;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_beat_cnt", {28'd0, beat_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        ticks(2);
        arst_n = 1'b1;
        ticks(1);

        // Full rate: five back-to-back reads and five back-to-back beats.
        clear_logs();
        load(1, 5);
        en = 1'b1;
        m_ready = 1'b1;
        ticks(12);
        check("t1_rd_total", rd_count(), 5);
        check("t1_rd_run", rd_maxrun(), 5);
        check_seq("t1", 1, 5);
        check("t1_beat_cnt", {28'd0, beat_cnt}, 32'd5);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // Sink stalled: the buffer fills with two words, then drains in order.
        clear_logs();
        m_ready = 1'b0;
        load(1, 5);
        ticks(6);
        check("t2_rd_total", rd_count(), 2);
        check("t2_m_valid", {31'd0, m_valid}, 32'd1);
        check("t2_m_data", {26'd0, m_data}, 32'd1);
        check("t2_busy", {31'd0, busy}, 32'd1);
        m_ready = 1'b1;
        ticks(10);
        check_seq("t2", 1, 5);
        check("t2_beat_cnt", {28'd0, beat_cnt}, 32'd10);

        // Sink ready toggling on every cycle.
        clear_logs();
        load(8'h11, 8);
        for (int i = 0; i < 30; i++) begin
            m_ready = (i % 2 == 0);
            tick();
        end
        m_ready = 1'b1;
        ticks(2);
        check_seq("t3", 8'h11, 8);
        check("t3_beat_cnt", {28'd0, beat_cnt}, 32'd2);

        // FIFO empty throughout.
        clear_logs();
        ticks(5);
        check("t4_rd_total", rd_count(), 0);
        check("t4_m_valid", {31'd0, m_valid}, 32'd0);

        // Enable is dropped one cycle after the first read.
        clear_logs();
        en = 1'b0;
        load(1, 5);
        tick();
        en = 1'b1;
        #1;
        check("t5_first_rd", {31'd0, fifo_rd_en}, 32'd1);
        tick();
        en = 1'b0;
        ticks(6);
        check("t5_rd_total", rd_count(), 1);
        check_seq("t5", 1, 1);
        check("t5_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset while the buffer is full.
        m_ready = 1'b0;
        en = 1'b1;
        ticks(4);
        check("t6_pre_valid", {31'd0, m_valid}, 32'd1);
        check("t6_pre_data", {26'd0, m_data}, 32'd2);
        check("t6_pre_busy", {31'd0, busy}, 32'd1);
        #1 arst_n = 1'b0;
        #1;
        check("t6_m_valid", {31'd0, m_valid}, 32'd0);
        check("t6_beat_cnt", {28'd0, beat_cnt}, 32'd0);
        check("t6_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        tick();
        arst_n = 1'b1;
        ticks(1);

        // Counter wrap: 17 words into a 4-bit counter.
        clear_logs();
        m_ready = 1'b1;
        load(8'h20, 17);
        ticks(26);
        check_seq("t7", 8'h20, 17);
        check("t7_beat_cnt", {28'd0, beat_cnt}, 32'd1);
        check("t7_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
